find_inv_bvmul_seq: RTL and testbench
=====================================

FIND_INV_BVMUL_SEQ -- requirements
Module: find_inv_bvmul_seq

Interface
REQ-001 The block SHALL take parameter W, default 4, as the bit-vector width of s, t and x; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a request is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-006 The block SHALL have port s, input, W bits: multiplier operand.
REQ-007 The block SHALL have port t, input, W bits: comparison bound.
REQ-008 The block SHALL have port op, input, 3 bits: predicate select. 0 sgt, 1 sge, 2 slt, 3 sle, 4 ugt, 5 ult, 6 eq, 7 ne.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port x, output, W bits: the witness.
REQ-012 The block SHALL have port found, output, 1 bit: 1 means x satisfies the predicate; 0 means no x exists.
REQ-013 The block SHALL have port busy, output, 1 bit: high in states SEARCH and DONE.

Function
REQ-014 The block SHALL find x such that P((x*s) mod 2^W, t) holds, where P is the predicate selected by op; signed ops SHALL use two's complement.
REQ-015 The block SHALL have exactly three states: IDLE, SEARCH and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in SEARCH and DONE it SHALL be 0.
REQ-017 On an edge with in_valid=1 and in_ready=1, the block SHALL register s, t and op, clear the candidate counter cnt to 0, and enter SEARCH.
REQ-018 Changes on s, t and op after acceptance SHALL have no effect.
REQ-019 In SEARCH, the block SHALL evaluate exactly one candidate per cycle: product = low W bits of cnt*s, compared against the registered t.
REQ-020 On a SEARCH edge where the candidate passes, the block SHALL set x=cnt and found=1, and enter DONE.
REQ-021 On a SEARCH edge where the candidate fails and cnt = 2^W-1, the block SHALL set x=0 and found=0, and enter DONE. cnt SHALL NOT wrap and restart.
REQ-022 On a SEARCH edge where the candidate fails and cnt < 2^W-1, the block SHALL increment cnt.
REQ-023 The returned x SHALL be the smallest unsigned witness.
REQ-024 Latency SHALL be k+1 clock edges from the accept edge to out_valid=1, where k is the returned x; with no witness, latency SHALL be 2^W edges.
REQ-025 In DONE, out_valid SHALL be 1, and x and found SHALL stay stable until an edge with out_ready=1; that edge SHALL return the block to IDLE.
REQ-026 A new request SHALL be accepted no earlier than the edge after the result handshake; no accept and result in the same cycle.
REQ-027 out_valid, x and found SHALL be registered outputs; in_ready and busy SHALL be decoded from state only.
REQ-028 The multiplier SHALL be combinational, with no combinational path from in_* or out_ready to any output.
REQ-029 in_valid while busy SHALL be ignored, and no request SHALL be queued.

Reset
REQ-030 With rst_n=0 at an edge, the block SHALL set: state IDLE, in_ready=1, out_valid=0, busy=0, x=0, found=0, cnt=0, and clear the registered operands.
REQ-031 Reset SHALL override any in-progress search or pending result; the aborted result SHALL never appear on out_valid.
REQ-032 With in_valid=1 during reset, the block SHALL NOT accept the request; acceptance is possible from the first edge with rst_n=1.

Verification (W=4)
REQ-033 Test sgt: s=3, t=5, op=0 -> x=2, found=1, out_valid 3 edges after accept.
REQ-034 Test no solution: s=5, t=0111, op=0 -> x=0, found=0, out_valid 16 edges after accept.
REQ-035 Test immediate hit: s=0, t=1111, op=0 (0 > -1) -> x=0, found=1, latency 1 edge.
REQ-036 Tests across ops: s=2, t=13, op=4 -> x=7; s=3, t=1, op=6 -> x=11; s=1, t=1000, op=2 -> found=0.
REQ-037 Test backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and s/t toggling -> x, found and out_valid stay stable, in_ready=0, and no second accept.
REQ-038 Test reset mid-search: rst_n=0 at cnt=6 of a 16-cycle search -> after the reset edge, out_valid=0 and in_ready=1; the next request completes normally.
REQ-039 The bench SHALL compare every result against an exhaustive reference model over all s, t and op for W=4, and over random samples for W=8.

Source files
------------

// File: rtl/find_inv_bvmul_seq.sv
// rtl/find_inv_bvmul_seq.sv - sequential search for the smallest x with P((x*s) mod 2^W, t)
//
// Purpose: accepts (s, t, op) on a valid/ready handshake, then tries x = 0, 1, 2, ...
// one candidate per clock. It stops at the first x whose truncated product x*s satisfies
// the selected predicate against t, or after the last candidate 2^W-1 when none does.
// The result is held until the consumer takes it.
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   block idle and able to accept a request
//   s          multiplier operand (W bits)
//   t          comparison bound (W bits)
//   op         predicate: 0 sgt, 1 sge, 2 slt, 3 sle, 4 ugt, 5 ult, 6 eq, 7 ne
//   out_valid  result valid (registered)
//   out_ready  consumer takes the result
//   x          smallest witness, 0 when none exists (registered)
//   found      1 when x is a witness, 0 when no witness exists (registered)
//   busy       searching or holding a result
module find_inv_bvmul_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic         found,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0] s_r;
    logic [W-1:0] t_r;
    logic [2:0]   op_r;
    logic [W-1:0] cnt;
    logic [W-1:0] prod;
    logic         pass;
    logic         last;

    // Only the registered operands feed the multiplier, so nothing on the input side
    // reaches an output combinationally.
    always_comb begin
        prod = cnt * s_r;
        last = (cnt == {W{1'b1}});
        pass = 1'b0;
        case (op_r)
            3'd0: pass = $signed(prod) >  $signed(t_r);
            3'd1: pass = $signed(prod) >= $signed(t_r);
            3'd2: pass = $signed(prod) <  $signed(t_r);
            3'd3: pass = $signed(prod) <= $signed(t_r);
            3'd4: pass = prod >  t_r;
            3'd5: pass = prod <  t_r;
            3'd6: pass = prod == t_r;
            3'd7: pass = prod != t_r;
            default: pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SEARCH;
            SEARCH:  if (pass || last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_r       <= '0;
            t_r       <= '0;
            op_r      <= '0;
            cnt       <= '0;
            x         <= '0;
            found     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_r  <= s;
                        t_r  <= t;
                        op_r <= op;
                        cnt  <= '0;
                    end
                end
                SEARCH: begin
                    if (pass) begin
                        x         <= cnt;
                        found     <= 1'b1;
                        out_valid <= 1'b1;
                    end else if (last) begin
                        // Exhausted without a witness; cnt stays put rather than wrapping.
                        x         <= '0;
                        found     <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_find_inv_bvmul_seq.sv
// tb/tb_find_inv_bvmul_seq.sv - self-checking bench for find_inv_bvmul_seq (W=4 and W=8)
module tb_find_inv_bvmul_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv4 = 1'b0, or4 = 1'b0;
    logic [3:0] s4 = '0, t4 = '0;
    logic [2:0] op4 = '0;
    logic       ir4, ov4, f4, b4;
    logic [3:0] x4;

    logic       iv8 = 1'b0, or8 = 1'b0;
    logic [7:0] s8 = '0, t8 = '0;
    logic [2:0] op8 = '0;
    logic       ir8, ov8, f8, b8;
    logic [7:0] x8;

    int n_assert = 0;
    int n_fail = 0;

    find_inv_bvmul_seq #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .s(s4), .t(t4), .op(op4),
        .out_valid(ov4), .out_ready(or4), .x(x4), .found(f4), .busy(b4)
    );

    find_inv_bvmul_seq #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .s(s8), .t(t8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .x(x8), .found(f8), .busy(b8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: scan every candidate in ascending order and apply the predicate
    // to plain integers (signed values obtained by subtracting 2^w when the MSB is set).
    function automatic void ref_find(input int w, input int sv, input int tv, input int opv,
                                     output int xo, output int fo);
        int m, p, sp, st;
        bit ok;
        m  = 1 << w;
        st = (tv >= m / 2) ? tv - m : tv;
        xo = 0;
        fo = 0;
        for (int k = 0; k < m; k++) begin
            p  = (k * sv) % m;
            sp = (p >= m / 2) ? p - m : p;
            case (opv)
                0: ok = sp > st;
                1: ok = sp >= st;
                2: ok = sp < st;
                3: ok = sp <= st;
                4: ok = p > tv;
                5: ok = p < tv;
                6: ok = p == tv;
                default: ok = p != tv;
            endcase
            if (ok && fo == 0) begin
                xo = k;
                fo = 1;
            end
        end
    endfunction

    // Presents one request, counts edges from the accept edge to out_valid, and
    // scrambles the inputs after acceptance so they must not matter.
    task automatic do_req(input int w, input int sv, input int tv, input int opv,
                          output int xo, output int fo, output int lat);
        int guard;
        guard = 0;
        if (w == 4) begin
            s4 = sv[3:0]; t4 = tv[3:0]; op4 = opv[2:0]; iv4 = 1'b1;
            while (!ir4 && guard < 50) begin tick(); guard++; end
        end else begin
            s8 = sv[7:0]; t8 = tv[7:0]; op8 = opv[2:0]; iv8 = 1'b1;
            while (!ir8 && guard < 50) begin tick(); guard++; end
        end
        if (guard >= 50) chk("accept_timeout", guard, 0);
        tick();
        iv4 = 1'b0; iv8 = 1'b0;
        s4 = 4'($urandom); t4 = 4'($urandom); op4 = 3'($urandom);
        s8 = 8'($urandom); t8 = 8'($urandom); op8 = 3'($urandom);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (((w == 4) ? !ov4 : !ov8) && lat < 400);
        if (lat >= 400) chk("result_timeout", lat, 0);
        xo = (w == 4) ? int'(x4) : int'(x8);
        fo = (w == 4) ? int'(f4) : int'(f8);
    endtask

    task automatic ack(input int w);
        if (w == 4) or4 = 1'b1; else or8 = 1'b1;
        tick();
        or4 = 1'b0; or8 = 1'b0;
        chk("ack_out_valid", (w == 4) ? int'(ov4) : int'(ov8), 0);
        chk("ack_in_ready", (w == 4) ? int'(ir4) : int'(ir8), 1);
    endtask

    task automatic check_req(input string tag, input int w, input int sv, input int tv,
                             input int opv);
        int xo, fo, lat, ex, ef;
        do_req(w, sv, tv, opv, xo, fo, lat);
        ref_find(w, sv, tv, opv, ex, ef);
        chk({tag, "_x"}, xo, ex);
        chk({tag, "_found"}, fo, ef);
        chk({tag, "_latency"}, lat, ef ? ex + 1 : (1 << w));
        ack(w);
    endtask

    initial begin
        int xo, fo, lat;

        // Reset with a request pending: it must not be taken.
        iv4 = 1'b1; s4 = 4'd3; t4 = 4'd5;
        tick(); tick();
        chk("rst_in_ready", int'(ir4), 1);
        chk("rst_out_valid", int'(ov4), 0);
        chk("rst_busy", int'(b4), 0);
        chk("rst_x", int'(x4), 0);
        chk("rst_found", int'(f4), 0);
        chk("rst_busy8", int'(b8), 0);
        iv4 = 1'b0;
        rst_n = 1'b1;

        // Directed cases with fixed expectations.
        do_req(4, 3, 5, 0, xo, fo, lat);
        chk("sgt_x", xo, 2); chk("sgt_found", fo, 1); chk("sgt_lat", lat, 3);
        // Backpressure: result held, inputs toggling, no second accept.
        for (int i = 0; i < 5; i++) begin
            iv4 = 1'b1; s4 = 4'($urandom); t4 = 4'($urandom);
            tick();
            chk("bp_out_valid", int'(ov4), 1);
            chk("bp_x", int'(x4), 2);
            chk("bp_found", int'(f4), 1);
            chk("bp_in_ready", int'(ir4), 0);
            chk("bp_busy", int'(b4), 1);
        end
        iv4 = 1'b0;
        ack(4);

        do_req(4, 5, 7, 0, xo, fo, lat);
        chk("nosol_x", xo, 0); chk("nosol_found", fo, 0); chk("nosol_lat", lat, 16);
        ack(4);
        do_req(4, 0, 15, 0, xo, fo, lat);
        chk("imm_x", xo, 0); chk("imm_found", fo, 1); chk("imm_lat", lat, 1);
        ack(4);
        do_req(4, 2, 13, 4, xo, fo, lat);
        chk("ugt_x", xo, 7); chk("ugt_found", fo, 1);
        ack(4);
        do_req(4, 3, 1, 6, xo, fo, lat);
        chk("eq_x", xo, 11); chk("eq_found", fo, 1);
        ack(4);
        do_req(4, 1, 8, 2, xo, fo, lat);
        chk("slt_found", fo, 0);
        ack(4);

        // Reset at cnt=6 of a search that would run 16 cycles.
        s4 = 4'd5; t4 = 4'd7; op4 = 3'd0; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0; iv4 = 1'b1;
        tick();
        chk("midrst_out_valid", int'(ov4), 0);
        chk("midrst_in_ready", int'(ir4), 1);
        tick();
        chk("midrst_no_accept", int'(b4), 0);
        rst_n = 1'b1; iv4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("midrst_no_stale_result", int'(ov4), 0);
        end
        check_req("after_rst", 4, 3, 5, 0);

        // Exhaustive W=4.
        for (int o = 0; o < 8; o++)
            for (int sv = 0; sv < 16; sv++)
                for (int tv = 0; tv < 16; tv++)
                    check_req("exh4", 4, sv, tv, o);

        // Random W=8.
        for (int i = 0; i < 40; i++)
            check_req("rnd8", 8, int'($urandom_range(255)), int'($urandom_range(255)),
                      int'($urandom_range(7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
